// File: rtl/myled_s00_axi_regs_pkg.sv
// Shared constants and helpers for the myLED S00_AXI register block.
package myled_pkg;

  // Register indices, selected by byte address bits [3:2].
  localparam logic [1:0] REG_LED     = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int unsigned NUM_REGS = 4;

  // AXI response code; this block never signals an error.
  localparam logic [1:0] RESP_OKAY = 2'b00;

  // Bit position of the blink enable inside the control register.
  localparam int unsigned CTRL_BLINK_EN = 0;

  typedef logic [1:0] reg_idx_t;

  // Merge new_val into old_val on the byte lanes enabled by strb.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] mask;
    mask = '0;
    for (int b = 0; b < 4; b++) begin
      mask[8*b +: 8] = {8{strb[b]}};
    end
    return (old_val & ~mask) | (new_val & mask);
  endfunction

endpackage

// File: rtl/myled_s00_axi_regs_if.sv
// AXI4-Lite S00_AXI bundle between the BFM master and the myLED register slave.
interface myled_s00_axi_regs_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);

  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr;
  logic [2:0]                      s00_axi_awprot;
  logic                            s00_axi_awvalid;
  logic                            s00_axi_awready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb;
  logic                            s00_axi_wvalid;
  logic                            s00_axi_wready;
  logic [1:0]                      s00_axi_bresp;
  logic                            s00_axi_bvalid;
  logic                            s00_axi_bready;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr;
  logic [2:0]                      s00_axi_arprot;
  logic                            s00_axi_arvalid;
  logic                            s00_axi_arready;
  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata;
  logic [1:0]                      s00_axi_rresp;
  logic                            s00_axi_rvalid;
  logic                            s00_axi_rready;

  modport master (
    output s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    output s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    output s00_axi_bready,
    output s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    output s00_axi_rready,
    input  s00_axi_awready, s00_axi_wready,
    input  s00_axi_bresp, s00_axi_bvalid,
    input  s00_axi_arready,
    input  s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );

  modport slave (
    input  s00_axi_awaddr, s00_axi_awprot, s00_axi_awvalid,
    input  s00_axi_wdata, s00_axi_wstrb, s00_axi_wvalid,
    input  s00_axi_bready,
    input  s00_axi_araddr, s00_axi_arprot, s00_axi_arvalid,
    input  s00_axi_rready,
    output s00_axi_awready, s00_axi_wready,
    output s00_axi_bresp, s00_axi_bvalid,
    output s00_axi_arready,
    output s00_axi_rdata, s00_axi_rresp, s00_axi_rvalid
  );

endinterface

// File: rtl/myled_s00_axi_regs_blink_timer.sv
// Blink timer: free-running half-period counter that toggles the LED phase.
module myled_blink_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  input  logic [31:0] period,
  output logic        phase
);

  logic [31:0] count_q;
  logic        phase_q;

  // Count clocks up to period-1, then wrap and flip the phase; idle/clear parks at (0, lit).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else if (clear || !enable) begin
      count_q <= '0;
      phase_q <= 1'b1;
    end else if (count_q == period - 32'd1) begin
      count_q <= '0;
      phase_q <= ~phase_q;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/myled_s00_axi_regs.sv
// myLED S00_AXI slave: four RW registers behind AXI4-Lite plus the blinking LED driver.
module myled_s00_axi_regs
  import myled_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
  parameter int unsigned LED_WIDTH          = 8
) (
  input  logic                       s00_axi_aclk,
  input  logic                       s00_axi_aresetn,
  myled_s00_axi_regs_if.slave        axi,
  output logic [LED_WIDTH-1:0]       led_o
);

  localparam int unsigned StrbWidth = C_S_AXI_DATA_WIDTH / 8;

  // Write-side holding buffers: AW and W may arrive in any order.
  logic                          aw_full_q;
  reg_idx_t                      aw_idx_q;
  logic                          w_full_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_data_q;
  logic [StrbWidth-1:0]          w_strb_q;
  logic                          bvalid_q;

  // Read side.
  logic                          rvalid_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_val;

  // Register file and LED output.
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [LED_WIDTH-1:0]          led_q;

  logic                          aw_hs;
  logic                          w_hs;
  logic                          ar_hs;
  logic                          do_write;
  reg_idx_t                      wr_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data;
  logic [StrbWidth-1:0]          wr_strb;

  logic                          blink_enable;
  logic                          blink_clear;
  logic                          phase;

  assign axi.s00_axi_awready = ~aw_full_q & ~bvalid_q;
  assign axi.s00_axi_wready  = ~w_full_q & ~bvalid_q;
  assign axi.s00_axi_bvalid  = bvalid_q;
  assign axi.s00_axi_bresp   = RESP_OKAY;
  assign axi.s00_axi_arready = ~rvalid_q;
  assign axi.s00_axi_rvalid  = rvalid_q;
  assign axi.s00_axi_rdata   = rdata_q;
  assign axi.s00_axi_rresp   = RESP_OKAY;

  assign aw_hs = axi.s00_axi_awvalid & axi.s00_axi_awready;
  assign w_hs  = axi.s00_axi_wvalid & axi.s00_axi_wready;
  assign ar_hs = axi.s00_axi_arvalid & axi.s00_axi_arready;

  // A half arriving this cycle bypasses its buffer so a same-cycle AW+W commits immediately.
  assign wr_idx   = aw_full_q ? aw_idx_q : axi.s00_axi_awaddr[3:2];
  assign wr_data  = w_full_q ? w_data_q : axi.s00_axi_wdata;
  assign wr_strb  = w_full_q ? w_strb_q : axi.s00_axi_wstrb;
  assign do_write = (aw_full_q | aw_hs) & (w_full_q | w_hs);

  // Write channel: fill holding buffers, commit when both halves present, then hold B.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
    end else begin
      if (bvalid_q && axi.s00_axi_bready) begin
        bvalid_q <= 1'b0;
      end
      if (do_write) begin
        aw_full_q <= 1'b0;
        w_full_q  <= 1'b0;
        bvalid_q  <= 1'b1;
      end else begin
        if (aw_hs) begin
          aw_full_q <= 1'b1;
          aw_idx_q  <= axi.s00_axi_awaddr[3:2];
        end
        if (w_hs) begin
          w_full_q <= 1'b1;
          w_data_q <= axi.s00_axi_wdata;
          w_strb_q <= axi.s00_axi_wstrb;
        end
      end
    end
  end

  // Register file update with byte-lane masking.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (do_write) begin
      regs_q[wr_idx] <= apply_wstrb(regs_q[wr_idx], wr_data, wr_strb);
    end
  end

  // Read mux: always sees pre-write contents, so a same-cycle write is not forwarded.
  always_comb begin
    rd_val = '0;
    unique case (axi.s00_axi_araddr[3:2])
      REG_LED:     rd_val = regs_q[REG_LED];
      REG_CTRL:    rd_val = regs_q[REG_CTRL];
      REG_PERIOD:  rd_val = regs_q[REG_PERIOD];
      REG_SCRATCH: rd_val = regs_q[REG_SCRATCH];
      default:     rd_val = '0;
    endcase
  end

  // Read channel: capture on AR handshake, hold until R handshake.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_val;
    end else if (rvalid_q && axi.s00_axi_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Retouching the control or period register restarts the blink cycle from the lit phase.
  assign blink_clear  = do_write & ((wr_idx == REG_CTRL) | (wr_idx == REG_PERIOD));
  assign blink_enable = regs_q[REG_CTRL][CTRL_BLINK_EN] & (regs_q[REG_PERIOD] != '0);

  myled_blink_timer u_blink_timer (
    .clk    (s00_axi_aclk),
    .rst_n  (s00_axi_aresetn),
    .enable (blink_enable),
    .clear  (blink_clear),
    .period (regs_q[REG_PERIOD]),
    .phase  (phase)
  );

  // Registered LED drive gated by the blink phase.
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      led_q <= '0;
    end else begin
      led_q <= regs_q[REG_LED][LED_WIDTH-1:0] & {LED_WIDTH{phase}};
    end
  end

  assign led_o = led_q;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_inputs;
  assign unused_inputs = ^{axi.s00_axi_awprot, axi.s00_axi_arprot,
                           axi.s00_axi_awaddr[1:0], axi.s00_axi_araddr[1:0]};

endmodule

// File: tb/tb_myled_s00_axi_regs.sv
// Scoreboard bench for myled_s00_axi_regs: driver pushes expectations, monitor checks responses.
module tb_myled_s00_axi_regs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] led;

  myled_s00_axi_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

  myled_s00_axi_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4),
    .LED_WIDTH          (8)
  ) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .axi             (axi),
    .led_o           (led)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: plain array of register contents.
  logic [31:0] model [4];
  logic [31:0] r_exp_q [$];
  logic [1:0]  b_exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_event(input string name);
    n_total++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: compares each R/B response the DUT hands over against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (axi.s00_axi_rvalid && axi.s00_axi_rready) begin
        if (r_exp_q.size() == 0) fail_event("r_unexpected");
        else begin
          check("rdata", axi.s00_axi_rdata, r_exp_q.pop_front());
          check("rresp", 32'(axi.s00_axi_rresp), 32'd0);
        end
      end
      if (axi.s00_axi_bvalid && axi.s00_axi_bready) begin
        if (b_exp_q.size() == 0) fail_event("b_unexpected");
        else check("bresp", 32'(axi.s00_axi_bresp), 32'(b_exp_q.pop_front()));
      end
    end
  end

  // Waits until the selected ready is seen together with valid at a rising edge.
  task automatic wait_ready(input int sel, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      case (sel)
        0:       seen = axi.s00_axi_awready;
        1:       seen = axi.s00_axi_wready;
        default: seen = axi.s00_axi_arready;
      endcase
      @(posedge clk);
    end
    if (!seen) fail_event({name, "_timeout"});
  endtask

  task automatic write_raw(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_lead, input int w_lead);
    fork
      begin
        repeat (aw_lead) @(posedge clk);
        #1;
        axi.s00_axi_awaddr  = addr;
        axi.s00_axi_awvalid = 1'b1;
        wait_ready(0, "aw");
        #1;
        axi.s00_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_lead) @(posedge clk);
        #1;
        axi.s00_axi_wdata  = data;
        axi.s00_axi_wstrb  = strb;
        axi.s00_axi_wvalid = 1'b1;
        wait_ready(1, "w");
        #1;
        axi.s00_axi_wvalid = 1'b0;
      end
    join
  endtask

  task automatic b_phase(input int stall);
    bit done;
    done = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("bvalid_hold", 32'(axi.s00_axi_bvalid), 32'd1);
      check("awready_blocked", 32'(axi.s00_axi_awready), 32'd0);
      check("wready_blocked", 32'(axi.s00_axi_wready), 32'd0);
    end
    if (stall > 0) step(1);
    axi.s00_axi_bready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (axi.s00_axi_bvalid) done = 1'b1;
    end
    if (!done) fail_event("bvalid_timeout");
    step(1);
    axi.s00_axi_bready = 1'b0;
  endtask

  task automatic read_raw(input logic [3:0] addr);
    #1;
    axi.s00_axi_araddr  = addr;
    axi.s00_axi_arvalid = 1'b1;
    wait_ready(2, "ar");
    #1;
    axi.s00_axi_arvalid = 1'b0;
  endtask

  task automatic r_phase(input int stall, input logic [31:0] exp);
    bit done;
    done = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("rvalid_hold", 32'(axi.s00_axi_rvalid), 32'd1);
      check("rdata_stable", axi.s00_axi_rdata, exp);
    end
    if (stall > 0) step(1);
    axi.s00_axi_rready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (axi.s00_axi_rvalid) done = 1'b1;
    end
    if (!done) fail_event("rvalid_timeout");
    step(1);
    axi.s00_axi_rready = 1'b0;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
    logic [31:0] cur;
    cur = model[addr[3:2]];
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) cur[8*b +: 8] = data[8*b +: 8];
    end
    model[addr[3:2]] = cur;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_lead, input int w_lead, input int b_stall);
    model_write(addr, data, strb);
    b_exp_q.push_back(2'b00);
    write_raw(addr, data, strb, aw_lead, w_lead);
    b_phase(b_stall);
  endtask

  task automatic do_read(input logic [3:0] addr, input int r_stall);
    logic [31:0] exp;
    exp = model[addr[3:2]];
    r_exp_q.push_back(exp);
    read_raw(addr);
    r_phase(r_stall, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  samp [48];
    logic [31:0] exp_r;
    int          run_len;
    int          runs_checked;
    bit          first_run;

    axi.s00_axi_awaddr  = '0;
    axi.s00_axi_awprot  = '0;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wdata   = '0;
    axi.s00_axi_wstrb   = '0;
    axi.s00_axi_wvalid  = 1'b0;
    axi.s00_axi_bready  = 1'b0;
    axi.s00_axi_araddr  = '0;
    axi.s00_axi_arprot  = '0;
    axi.s00_axi_arvalid = 1'b0;
    axi.s00_axi_rready  = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("rst_awready", 32'(axi.s00_axi_awready), 32'd1);
    check("rst_wready", 32'(axi.s00_axi_wready), 32'd1);
    check("rst_arready", 32'(axi.s00_axi_arready), 32'd1);
    check("rst_bvalid", 32'(axi.s00_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(axi.s00_axi_rvalid), 32'd0);
    check("rst_rdata", axi.s00_axi_rdata, 32'd0);
    check("rst_led", 32'(led), 32'd0);

    // Basic write/readback of all four registers.
    for (int i = 0; i < 4; i++) do_write(4'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(4'(4 * i), 0);
    @(negedge clk);
    check("led_reg0", 32'(led), 32'h01);
    step(0);
    @(posedge clk);
    #1;

    // AW ahead of W, then W ahead of AW.
    do_write(4'h0, 32'hA5, 4'hF, 0, 3, 0);
    do_read(4'h0, 0);
    do_write(4'h0, 32'h3C, 4'hF, 3, 0, 0);
    do_read(4'h0, 0);
    do_write(4'h0, 32'hA5, 4'hF, 0, 0, 0);

    // Byte-lane masking.
    do_write(4'hC, 32'h0, 4'hF, 0, 0, 0);
    do_write(4'hC, 32'hFFFF_FFFF, 4'b0010, 0, 0, 0);
    do_read(4'hC, 0);
    check("wstrb_model", model[3], 32'h0000_FF00);

    // Response back-pressure.
    do_write(4'h8, 32'h1234_5678, 4'hF, 0, 0, 5);
    do_read(4'h8, 5);

    // Same-cycle read and write to one register returns the old value.
    do_write(4'hC, 32'h1111_2222, 4'hF, 0, 0, 0);
    exp_r = model[3];
    r_exp_q.push_back(exp_r);
    model_write(4'hC, 32'h3333_4444, 4'hF);
    b_exp_q.push_back(2'b00);
    fork
      begin write_raw(4'hC, 32'h3333_4444, 4'hF, 0, 0); b_phase(0); end
      begin read_raw(4'hC); r_phase(0, exp_r); end
    join
    do_read(4'hC, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(4'($urandom), $urandom, 4'($urandom), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(4'($urandom), $urandom_range(0, 2));
    end

    // Blink: half-period of 4 clocks.
    do_write(4'h0, 32'hFF, 4'hF, 0, 0, 0);
    do_write(4'h8, 32'd4, 4'hF, 0, 0, 0);
    do_write(4'h4, 32'd1, 4'hF, 0, 0, 0);
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      samp[i] = led;
    end
    run_len = 1;
    runs_checked = 0;
    first_run = 1'b1;
    for (int i = 0; i < 48; i++) begin
      check("blink_level", 32'((samp[i] == 8'hFF) || (samp[i] == 8'h00)), 32'd1);
    end
    for (int i = 1; i < 48; i++) begin
      if (samp[i] == samp[i-1]) run_len++;
      else begin
        if (!first_run) begin
          check("blink_run_len", 32'(run_len), 32'd4);
          runs_checked++;
        end
        first_run = 1'b0;
        run_len = 1;
      end
    end
    check("blink_runs_seen", 32'(runs_checked >= 4), 32'd1);
    step(1);
    do_write(4'h4, 32'd0, 4'hF, 0, 0, 0);
    step(2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("led_steady", 32'(led), 32'hFF);
    end
    step(1);

    // Reset while a write response is pending.
    axi.s00_axi_awaddr  = 4'h0;
    axi.s00_axi_wdata   = 32'h77;
    axi.s00_axi_wstrb   = 4'hF;
    axi.s00_axi_awvalid = 1'b1;
    axi.s00_axi_wvalid  = 1'b1;
    @(posedge clk);
    #1;
    axi.s00_axi_awvalid = 1'b0;
    axi.s00_axi_wvalid  = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", 32'(axi.s00_axi_bvalid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", 32'(axi.s00_axi_bvalid), 32'd0);
    check("mid_rst_led", 32'(led), 32'd0);
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1);
    check("post_rst_awready", 32'(axi.s00_axi_awready), 32'd1);
    check("post_rst_wready", 32'(axi.s00_axi_wready), 32'd1);
    check("post_rst_arready", 32'(axi.s00_axi_arready), 32'd1);
    axi.s00_axi_bready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_no_b", 32'(axi.s00_axi_bvalid), 32'd0);
    end
    step(1);
    axi.s00_axi_bready = 1'b0;
    for (int i = 0; i < 4; i++) do_read(4'(4 * i), 0);

    step(3);
    check("r_queue_drained", 32'(r_exp_q.size()), 32'd0);
    check("b_queue_drained", 32'(b_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/myled_s00_axi_regs.md
# myled_s00_axi_regs

AXI4-Lite slave that owns the myLED peripheral's S00_AXI register file: four 32-bit read/write registers plus an LED driver with an optional blink timer. It is the responder end of the S00_AXI interface driven by the master VIP in the BFM example design, and sits directly under the myLED_v1_0 top. Every write must read back bit-exact; register 0 drives the board LEDs.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data bus width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 4, byte address width; addr[3:2] selects register
- LED_WIDTH, 8, number of LED outputs (1..32)

- s00_axi_aclk  in  1  single clock
- s00_axi_aresetn  in  1  asynchronous active-low reset
- s00_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s00_axi_awprot  in  3  ignored
- s00_axi_awvalid / s00_axi_awready  in / out  1  AW handshake
- s00_axi_wdata  in  32  write data
- s00_axi_wstrb  in  4  byte enables
- s00_axi_wvalid / s00_axi_wready  in / out  1  W handshake
- s00_axi_bresp  out  2  always 2'b00 (OKAY)
- s00_axi_bvalid / s00_axi_bready  out / in  1  B handshake
- s00_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s00_axi_arprot  in  3  ignored
- s00_axi_arvalid / s00_axi_arready  in / out  1  AR handshake
- s00_axi_rdata  out  32  read data
- s00_axi_rresp  out  2  always 2'b00
- s00_axi_rvalid / s00_axi_rready  out / in  1  R handshake
- led_o  out  LED_WIDTH  LED drive

## Operation
- Registers: REG0 LED value; REG1 control (bit0 blink_en, other bits plain storage); REG2 blink half-period in clocks; REG3 scratch. All fully RW, reset 0.
- addr[1:0] and bits above [3:2] ignored. No error responses.
- Write channel: AW and W are latched independently into one-entry holding buffers; either order or same cycle accepted. awready = AW buffer empty and bvalid low; wready likewise for W. When both buffers full: apply write with WSTRB byte masking, clear both buffers, set bvalid.
- No new AW/W accepted while bvalid high.
- Read channel: arready = rvalid low. On AR handshake, capture register at araddr[3:2] into rdata, set rvalid.
- Read and write channels are independent; same-cycle read and write to the same register return the pre-write value.
- Blink: blink_en=0 or REG2=0 -> counter held 0, phase held 1. Otherwise counter increments each clock; at REG2-1 wraps to 0 and phase toggles. Any write to REG2 or REG1 clears counter to 0 and phase to 1.
- led_o = REG0[LED_WIDTH-1:0] & {LED_WIDTH{phase}}.

## Timing
- Reset (async assert, sync release): awready, wready, arready = 1 after release; bvalid, rvalid, rdata, led_o = 0; buffers empty; counter 0; phase 1.
- Write: AW and W same cycle at edge N -> register updated at N+1, bvalid high from N+1 until bready sampled high. Back-to-back: next AW/W accepted the cycle after B handshake.
- Read: AR handshake at edge N -> rvalid and rdata valid from N+1, held stable until rready sampled high; arready re-asserts the cycle after R handshake.
- led_o is registered: reflects REG0 one cycle after the register update.
- Reset mid-transaction: all pending AW/W/B/R state discarded; no response issued afterwards.

## Structure
- Package myled_pkg: register index constants (REG_LED=0, REG_CTRL=1, REG_PERIOD=2, REG_SCRATCH=3), RESP_OKAY=2'b00, CTRL_BLINK_EN bit position.
- Sub-module myled_blink_timer: counter, phase, clear input; instantiated once.

## Test plan
- Write 0x1,0x2,0x3,0x4 to addrs 0x0,0x4,0x8,0xC, then read back -> rdata 0x1..0x4, rresp 0, led_o = 0x01.
- AW issued 3 cycles before W (and reverse) to 0x0, data 0xA5 -> single bvalid after both, REG0 = 0xA5.
- WSTRB=4'b0010, wdata 0xFFFFFFFF to 0xC holding 0x0 -> readback 0x0000FF00.
- bready held low 5 cycles -> bvalid stays high, awready/wready low throughout; rready low 5 cycles -> rdata stable.
- REG0=0xFF, REG2=4, REG1=1 -> led_o alternates 0xFF/0x00 every 4 clocks; REG1=0 -> led_o 0xFF steady.
- Reset asserted while bvalid pending -> bvalid drops immediately, all registers read 0 after release.
